// File: rtl/s_axi_rd_slave.sv
// s_axi_rd_slave: AXI4-Lite read-only slave over a DEPTH x 32-bit register array.
// Latency: rvalid rises WAIT_STATES+1 cycles after the AR handshake; one read outstanding.
// Backpressure: response held stable until rready; arready low from acceptance until the R handshake.
// Ports:
//   s_axi_aclk, s_axi_aresetn          clock, asynchronous active-low reset
//   s_axi_arvalid/arready/araddr       read address channel
//   s_axi_rvalid/rready/rdata/rresp    read data channel (2'b00 OKAY, 2'b10 SLVERR)
//   i_lwr_en/i_lwr_idx/i_lwr_data      local write port into the array, honoured in any state
//   o_busy                             high while a read is in flight (WAIT or RESP)
module s_axi_rd_slave #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  localparam int unsigned IDX_W      = $clog2(DEPTH)
) (
  input  logic             s_axi_aclk,
  input  logic             s_axi_aresetn,
  input  logic             s_axi_arvalid,
  output logic             s_axi_arready,
  input  logic [31:0]      s_axi_araddr,
  output logic             s_axi_rvalid,
  input  logic             s_axi_rready,
  output logic [31:0]      s_axi_rdata,
  output logic [1:0]       s_axi_rresp,
  input  logic             i_lwr_en,
  input  logic [IDX_W-1:0] i_lwr_idx,
  input  logic [31:0]      i_lwr_data,
  output logic             o_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  localparam logic [3:0]  CNT_LOAD    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [31:0] DEPTH_W     = 32'(DEPTH);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] mem_q [DEPTH];

  logic             ar_hs, r_hs;
  logic [31:0]      offset;
  logic             hit;
  logic [IDX_W-1:0] idx;

  assign ar_hs = s_axi_arvalid && arready_q;
  assign r_hs  = rvalid_q && s_axi_rready;

  // Decode works on the captured address, so araddr may change freely after acceptance.
  assign offset = addr_q - BASE_ADDR;
  assign hit    = (offset[1:0] == 2'b00) && ({2'b00, offset[31:2]} < DEPTH_W);
  assign idx    = offset[IDX_W+1:2];

  // State register
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ar_hs) state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt_q == 4'd0) state_d = ST_RESP;
      ST_RESP: if (r_hs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (state_q)
      ST_IDLE: begin
        // arready comes up one edge after reset release, then stays up until a handshake.
        arready_d = 1'b1;
        if (ar_hs) begin
          addr_d    = s_axi_araddr;
          arready_d = 1'b0;
          cnt_d     = CNT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      end
      ST_RESP: begin
        // First RESP cycle reads the array; the response registers load on the edge
        // that ends it, which gives the WAIT_STATES+1 latency. A local write on that
        // same edge is not seen because mem_q still holds the old value.
        if (!rvalid_q) begin
          rvalid_d = 1'b1;
          rdata_d  = hit ? mem_q[idx] : 32'h0;
          rresp_d  = hit ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axi_rready) begin
          rvalid_d  = 1'b0;
          rdata_d   = 32'h0;
          rresp_d   = 2'b00;
          arready_d = 1'b1;
        end
      end
      default: begin
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      cnt_q     <= 4'd0;
      addr_q    <= 32'h0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      rresp_q   <= 2'b00;
    end else begin
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Register array: local writes land in any FSM state.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 32'h0;
    end else if (i_lwr_en) begin
      mem_q[i_lwr_idx] <= i_lwr_data;
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: doc/s_axi_rd_slave.md
S_AXI_RD_SLAVE -- requirements
Module: s_axi_rd_slave

Interface
REQ-001 Parameter DEPTH, default 16, number of 32-bit register entries (power of two, 2..256).
REQ-002 Parameter WAIT_STATES, default 2, extra cycles between address acceptance and rvalid (0..15).
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000, byte address of entry 0.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Port s_axi_aclk  input  1  clock; all state updates on its rising edge.
REQ-006 Port s_axi_aresetn  input  1  asynchronous active-low reset.
REQ-007 Port s_axi_arvalid  input  1  read address valid from the master.
REQ-008 Port s_axi_arready  output  1  read address ready.
REQ-009 Port s_axi_araddr  input  32  read byte address.
REQ-010 Port s_axi_rvalid  output  1  read data valid.
REQ-011 Port s_axi_rready  input  1  read data ready from the master.
REQ-012 Port s_axi_rdata  output  32  read data.
REQ-013 Port s_axi_rresp  output  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-014 Port i_lwr_en  input  1  local write strobe into the register array.
REQ-015 Port i_lwr_idx  input  log2(DEPTH)  local write entry index.
REQ-016 Port i_lwr_data  input  32  local write data.
REQ-017 Port o_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-018 FSM states SHALL be IDLE, WAIT and RESP; s_axi_arready SHALL be 1 only in IDLE.
REQ-019 IDLE: on s_axi_arvalid && s_axi_arready, the block SHALL register s_axi_araddr, drop arready next cycle and go to WAIT (WAIT_STATES>0) or RESP (WAIT_STATES=0).
REQ-020 WAIT: a 4-bit counter loaded with WAIT_STATES-1 at acceptance SHALL decrement each cycle; at 0 the FSM SHALL go to RESP.
REQ-021 On entry to RESP, s_axi_rvalid, s_axi_rdata and s_axi_rresp SHALL be registered together, so rvalid rises exactly WAIT_STATES+1 cycles after the address-handshake edge.
REQ-022 Decode: offset = araddr - BASE_ADDR (32-bit modulo); hit when offset[1:0]==0 and offset[31:2] < DEPTH.
REQ-023 Hit: rdata = entry offset[31:2], rresp = 2'b00; miss or misaligned: rdata = 32'h0, rresp = 2'b10.
REQ-024 RESP: rvalid, rdata and rresp SHALL stay stable until s_axi_rready is sampled high with rvalid high, for any rready stall length.
REQ-025 On the rvalid && rready edge, the block SHALL clear rvalid, rdata and rresp to 0, set arready to 1 and return to IDLE; back-to-back reads are therefore at least WAIT_STATES+3 cycles apart.
REQ-026 s_axi_arvalid SHALL be ignored outside IDLE; s_axi_araddr changes after acceptance SHALL not affect the response.
REQ-027 When i_lwr_en is high, entry i_lwr_idx SHALL take i_lwr_data on the edge, in any FSM state.
REQ-028 If a local write to the hit entry occurs on the same edge as RESP entry, the response SHALL carry the pre-write (old) value; later reads return the new value.
REQ-029 A local write to an entry already captured in rdata SHALL not alter rdata during RESP.
REQ-030 o_busy SHALL be 1 in WAIT and RESP and 0 in IDLE.

Reset
REQ-031 While s_axi_aresetn is low, and immediately on its falling edge, arready, rvalid, rdata, rresp, o_busy, the counter and all DEPTH entries SHALL be 0 and the FSM SHALL be in IDLE.
REQ-032 Reset asserted in WAIT or RESP SHALL abort the transaction with no response produced after release.
REQ-033 arready SHALL rise on the first rising edge after s_axi_aresetn deasserts.

Verification
REQ-034 Local write idx 3 = 32'hDEAD_BEEF, read araddr 32'h0C, rready held high -> rvalid 3 cycles after handshake, rdata 32'hDEAD_BEEF, rresp 2'b00.
REQ-035 Read araddr 32'h40 (DEPTH=16) and 32'h06 -> each rdata 32'h0, rresp 2'b10; FSM returns to IDLE.
REQ-036 rready held low 10 cycles after rvalid -> rvalid/rdata/rresp stable throughout; one transfer on rready rise; arready 1 next cycle.
REQ-037 Local write idx 5 = 32'h1234_5678 on the RESP-entry edge of a read of entry 5 holding 32'hAAAA_0000 -> rdata 32'hAAAA_0000; next read 32'h1234_5678.
REQ-038 Reset pulsed during WAIT -> rvalid stays 0, o_busy 0, entries read back 32'h0, arready 1 one edge after release.
REQ-039 arvalid held high continuously with rready high and WAIT_STATES=0 -> one accepted address every 3 cycles, rvalid never asserted while arready is 1.
